ifetch_ctrl: RTL and testbench

Instruction fetch controller that sequences the word-addressed, combinational-read instruction memory (`imem`) on behalf of the core. It owns the fetch PC, issues one `imem` read per cycle, and buffers fetched words with their PCs in a small prefetch FIFO. The FIFO is drained by decode through a valid/ready handshake, and a redirect port handles branches and jumps. It sits between `imem` and the decode stage of the 32-bit RISC core.

---
 rtl/ifetch_ctrl.sv | 102 ++++++++++
 tb/tb_ifetch_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, reads imem once per cycle and buffers
// {instr, pc} pairs in a small prefetch FIFO drained by decode. Optional macro: IFETCH_FAULT_EN.
module ifetch_ctrl #(
  parameter int unsigned   n        = 32,
  parameter int unsigned   r        = 6,
  parameter int unsigned   DEPTH    = 2,
  parameter logic [n-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [r-1:0]  imem_addr,
  input  logic [n-1:0]  imem_rdata,
  output logic          instr_valid,
  output logic [n-1:0]  instr,
  output logic [n-1:0]  instr_pc,
  input  logic          instr_ready,
  input  logic          redirect,
  input  logic [n-1:0]  redirect_pc,
  output logic          fault,
  output logic [n-1:0]  fault_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e          state_q, state_d;
  logic [n-1:0]    fetch_pc_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_after_pop;
  logic [n-1:0]    mem_instr [DEPTH];
  logic [n-1:0]    mem_pc    [DEPTH];
  logic            fetch_ok, push, pop;

  assign imem_addr = fetch_pc_q[r+1:2];

`ifdef IFETCH_FAULT_EN
  assign fetch_ok = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q[n-1:r+2] == '0);
  assign fault    = (state_q == StFault);
  assign fault_pc = fault ? fetch_pc_q : '0;
`else
  assign fetch_ok = 1'b1;
  assign fault    = 1'b0;
  assign fault_pc = '0;
`endif

  // No pushes happen in StFault, so count is already 0 there.
  assign instr_valid = (state_q == StRun) && (count_q != '0);
  assign instr       = instr_valid ? mem_instr[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr_q]    : '0;

  always_comb begin
    pop             = instr_valid & instr_ready;
    push            = (state_q == StRun) & ~redirect & fetch_ok &
                      ((count_q < CW'(DEPTH)) | pop);
    count_after_pop = count_q - CW'(pop);
    state_d         = state_q;
    if (redirect) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun:   if (!fetch_ok && count_after_pop == '0) state_d = StFault;
        StFault: state_d = StFault;
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect) begin
      state_q    <= StRun;
      fetch_pc_q <= redirect_pc;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + AW'(1);
        fetch_pc_q <= fetch_pc_q + n'(4);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_after_pop + CW'(push);
    end
  end

  // Payload storage needs no reset; reads are gated by instr_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= imem_rdata;
      mem_pc[wr_ptr_q]    <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed, table-driven bench for ifetch_ctrl with a combinational imem model
// returning 32'h1000_0000 + word address.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;

  ifetch_ctrl #(.n(32), .r(6), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fault       (fault),
    .fault_pc    (fault_pc)
  );

  always #5 clk = ~clk;

  assign imem_rdata = 32'h1000_0000 + {26'd0, imem_addr};

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] epc;
    logic [5:0]  ea;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] ei,
                         input logic [31:0] epc, input logic [5:0] ea);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, ev});
    chk({tag, ".instr"}, instr, ei);
    chk({tag, ".pc"}, instr_pc, epc);
    chk({tag, ".addr"}, {26'd0, imem_addr}, {26'd0, ea});
  endtask

  initial begin
    int nvec;
    // rdy redir rpc  valid instr          pc        addr
    vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   6'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0000, 32'h0,   6'd1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0000, 32'h0,   6'd2};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0000, 32'h0,   6'd2};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0000, 32'h0,   6'd2};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0000, 32'h0,   6'd2};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1000_0000, 32'h0,   6'd2};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1000_0001, 32'h4,   6'd3};
    vecs[8]  = '{1'b0, 1'b1, 32'h20,  1'b1, 32'h1000_0002, 32'h8,   6'd4};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   6'd8};
    vecs[10] = '{1'b1, 1'b1, 32'h102, 1'b1, 32'h1000_0008, 32'h20,  6'd9};
    vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   6'd0};
    vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1000_0000, 32'h102, 6'd1};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0001, 32'h106, 6'd2};
    vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0001, 32'h106, 6'd3};
`ifdef IFETCH_FAULT_EN
    nvec = 10;  // misaligned redirect rows would fault in this build
`else
    nvec = 15;
`endif

    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    reset       = 1'b1;
    #1;
    chk_out("reset", 1'b0, 32'h0, 32'h0, 6'd0);
    chk("reset.fault", {31'd0, fault}, 32'h0);
    chk("reset.fault_pc", fault_pc, 32'h0);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      instr_ready = vecs[i].rdy;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].epc, vecs[i].ea);
      chk($sformatf("vec%0d.fault", i), {31'd0, fault}, 32'h0);
      chk($sformatf("vec%0d.fault_pc", i), fault_pc, 32'h0);
      step();
    end
    instr_ready = 1'b0;
    redirect    = 1'b0;

    // Asynchronous reset with entries buffered, well before the next edge.
    #1 reset = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 32'h0, 6'd0);
    #1 reset = 1'b0;
    #1;
    chk_out("post_rst", 1'b0, 32'h0, 32'h0, 6'd0);
    instr_ready = 1'b1;
    step();
    chk_out("post_rst_first", 1'b1, 32'h1000_0000, 32'h0, 6'd1);

`ifdef IFETCH_FAULT_EN
    redirect    = 1'b1;
    redirect_pc = 32'hF8;
    step();
    redirect = 1'b0;
    chk_out("flt_a", 1'b0, 32'h0, 32'h0, 6'h3E);
    step();
    chk_out("flt_b", 1'b1, 32'h1000_003E, 32'hF8, 6'h3F);
    step();
    chk_out("flt_c", 1'b1, 32'h1000_003F, 32'hFC, 6'h00);
    chk("flt_c.fault", {31'd0, fault}, 32'h0);
    step();
    chk_out("flt_d", 1'b0, 32'h0, 32'h0, 6'h00);
    chk("flt_d.fault", {31'd0, fault}, 32'h1);
    chk("flt_d.fault_pc", fault_pc, 32'h100);
    step();
    chk("flt_hold.fault", {31'd0, fault}, 32'h1);
    chk("flt_hold.valid", {31'd0, instr_valid}, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    chk("flt_clr.fault", {31'd0, fault}, 32'h0);
    chk("flt_clr.fault_pc", fault_pc, 32'h0);
    step();
    chk_out("flt_clr_first", 1'b1, 32'h1000_0000, 32'h0, 6'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
